uart_memory_host: RTL

- Initiator side of the UART memory protocol: accepts one read or write request on a parallel interface and serialises it into protocol bytes for a uart instance.
  - Read: collects the returned bytes and delivers them.
  - Write: pulls the write data one byte at a time from the user.
- Sits between a host-side sequencer (test harness, or a second FPGA acting as master) and the uart transmit/receive ports.
- Frame: command byte (1 = read, 2 = write), count byte (N-1), address high byte, address low byte, then N data bytes (sent for a write, received for a read).

---
 rtl/uart_memory_host.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_memory_host.sv
// Initiator side of the UART memory protocol: serialises one read/write request
// into cmd/count/addr/data bytes for a uart and collects or supplies the data bytes.
module uart_memory_host #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd240000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_write,
    input  logic [15:0] addr,
    input  logic [7:0]  count,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        is_transmitting
);

    localparam logic [3:0] IDLE         = 4'd0;
    localparam logic [3:0] SEND_CMD     = 4'd1;
    localparam logic [3:0] SEND_COUNT   = 4'd2;
    localparam logic [3:0] SEND_ADDR_HI = 4'd3;
    localparam logic [3:0] SEND_ADDR_LO = 4'd4;
    localparam logic [3:0] SEND_DATA    = 4'd5;
    localparam logic [3:0] TX_GUARD     = 4'd6;
    localparam logic [3:0] WR_FETCH     = 4'd7;
    localparam logic [3:0] WR_DRAIN     = 4'd8;
    localparam logic [3:0] RD_WAIT      = 4'd9;
    localparam logic [3:0] RD_COLLECT   = 4'd10;

    logic [3:0]  state;
    logic [3:0]  ret_state;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  remaining;
    logic [7:0]  wr_byte;
    logic [23:0] tmr;

    logic        sending;
    logic [7:0]  send_byte;
    logic [3:0]  send_next;

    // Byte to emit and where to go after its guard cycle, for every send state.
    // remaining still holds the requested count while the header goes out.
    always_comb begin
        sending   = 1'b0;
        send_byte = 8'h00;
        send_next = IDLE;
        case (state)
            SEND_CMD: begin
                sending   = 1'b1;
                send_byte = req_write ? 8'h02 : 8'h01;
                send_next = SEND_COUNT;
            end
            SEND_COUNT: begin
                sending   = 1'b1;
                send_byte = remaining;
                send_next = SEND_ADDR_HI;
            end
            SEND_ADDR_HI: begin
                sending   = 1'b1;
                send_byte = req_addr[15:8];
                send_next = SEND_ADDR_LO;
            end
            SEND_ADDR_LO: begin
                sending   = 1'b1;
                send_byte = req_addr[7:0];
                send_next = req_write ? WR_FETCH : RD_WAIT;
            end
            SEND_DATA: begin
                sending   = 1'b1;
                send_byte = wr_byte;
                send_next = (remaining == 8'd0) ? WR_DRAIN : WR_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ret_state <= IDLE;
            req_write <= 1'b0;
            req_addr  <= 16'h0000;
            remaining <= 8'd0;
            wr_byte   <= 8'h00;
            tmr       <= 24'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            transmit  <= 1'b0;
            rd_valid  <= 1'b0;
            wr_ready  <= 1'b0;
            tx_byte   <= 8'h00;
            rd_data   <= 8'h00;
        end else begin
            transmit <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            rd_valid <= 1'b0;
            if (sending && !is_transmitting) begin
                // uart raises is_transmitting a cycle late, so TX_GUARD masks that gap
                tx_byte   <= send_byte;
                transmit  <= 1'b1;
                ret_state <= send_next;
                state     <= TX_GUARD;
                if (state == SEND_DATA && remaining != 8'd0)
                    remaining <= remaining - 8'd1;
            end else begin
                case (state)
                    IDLE: begin
                        // busy is still high in the done/timeout cycle, so a start there is ignored
                        if (start && !busy) begin
                            busy      <= 1'b1;
                            req_write <= is_write;
                            req_addr  <= addr;
                            remaining <= count;
                            state     <= SEND_CMD;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    SEND_CMD, SEND_COUNT, SEND_ADDR_HI, SEND_ADDR_LO, SEND_DATA: ;
                    TX_GUARD: begin
                        state <= ret_state;
                        if (ret_state == WR_FETCH)
                            wr_ready <= 1'b1;
                    end
                    WR_FETCH: begin
                        if (wr_valid && wr_ready) begin
                            wr_ready <= 1'b0;
                            wr_byte  <= wr_data;
                            state    <= SEND_DATA;
                        end
                    end
                    WR_DRAIN: begin
                        if (!is_transmitting) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    RD_WAIT: begin
                        if (!is_transmitting) begin
                            tmr   <= 24'd0;
                            state <= RD_COLLECT;
                        end
                    end
                    RD_COLLECT: begin
                        // an arrival on the expiry cycle wins over the timeout
                        if (received) begin
                            rd_data  <= rx_byte;
                            rd_valid <= 1'b1;
                            tmr      <= 24'd0;
                            if (remaining == 8'd0) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                remaining <= remaining - 8'd1;
                            end
                        end else if (tmr == TIMEOUT_CYCLES - 24'd2) begin
                            timeout <= 1'b1;
                            tmr     <= 24'd0;
                            state   <= IDLE;
                        end else begin
                            tmr <= tmr + 24'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
